// File: rtl/npc_sequencer_pkg.sv
// Shared decode constants, FSM encoding and reset vector for the next-PC sequencer.
package npc_sequencer_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_3000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/npc_sequencer_target_calc.sv
// Combinational decode of control transfers: taken condition, target address and link value.
module npc_target_calc
    import npc_sequencer_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]     instr_D,
    input  logic            valid_D,
    input  logic [PC_W-1:0] pc_D,
    input  logic [31:0]     rs_val_D,
    input  logic [31:0]     rt_val_D,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic [PC_W-1:0] link
);

    logic [5:0]         op;
    logic [5:0]         funct;
    logic signed [31:0] br_off;
    logic [PC_W-1:0]    br_tgt;
    logic [PC_W-1:0]    j_tgt;
    logic [PC_W-1:0]    jr_tgt;

    assign op     = instr_D[31:26];
    assign funct  = instr_D[5:0];
    assign br_off = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
    assign br_tgt = pc_D + PC_W'(3'd4) + PC_W'(br_off);
    // Upper region bits come from pc_D only when PC_W is wide enough to have them.
    assign j_tgt  = (pc_D & ~PC_W'(28'hFFF_FFFF)) | PC_W'({instr_D[25:0], 2'b00});
    assign jr_tgt = PC_W'(rs_val_D);
    assign link   = pc_D + PC_W'(4'd8);

    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (op)
            OP_BEQ: begin
                taken  = valid_D && (rs_val_D == rt_val_D);
                target = br_tgt;
            end
            OP_BNE: begin
                taken  = valid_D && (rs_val_D != rt_val_D);
                target = br_tgt;
            end
            OP_J, OP_JAL: begin
                taken  = valid_D;
                target = j_tgt;
            end
            OP_SPECIAL: begin
                if ((funct == FN_JR) || (funct == FN_JALR)) begin
                    taken  = valid_D;
                    target = jr_tgt;
                end
            end
            default: begin
                taken  = 1'b0;
                target = br_tgt;
            end
        endcase
    end

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC sequencer: owns pc_F and parks a redirect target while imem is not ready.
// NPC_DELAY_SLOT_EN selects MIPS delay-slot behaviour (no decode flush).
//   state   | meaning
//   ST_RUN  | normal fetch; redirects apply directly when imem accepts
//   ST_PEND | redirect target parked in pend_pc, waiting for fetch_ready
module npc_sequencer
    import npc_sequencer_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEFAULT_RESET_VEC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_D,
    input  logic            valid_D,
    input  logic [PC_W-1:0] pc_D,
    input  logic [31:0]     rs_val_D,
    input  logic [31:0]     rt_val_D,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic [PC_W-1:0] pc_F,
    output logic            fetch_valid,
    output logic            flush_D,
    output logic [PC_W-1:0] link_D,
    output logic            redirect
);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_pc;
    logic            taken;
    logic [PC_W-1:0] target;

    npc_target_calc #(
        .PC_W (PC_W)
    ) u_target_calc (
        .instr_D  (instr_D),
        .valid_D  (valid_D),
        .pc_D     (pc_D),
        .rs_val_D (rs_val_D),
        .rt_val_D (rt_val_D),
        .taken    (taken),
        .target   (target),
        .link     (link_D)
    );

    assign pc_F        = pc_q;
    assign fetch_valid = ~reset;
    // A stalled transfer is simply not acted on; it is re-evaluated once decode moves again.
    assign redirect    = ~reset && (state == ST_RUN) && ~stall && taken;

`ifdef NPC_DELAY_SLOT_EN
    assign flush_D = 1'b0;
`else
    assign flush_D = ~reset && ((state == ST_RUN) ? (redirect && fetch_ready) : fetch_ready);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            pend_pc <= '0;
            state   <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (fetch_ready) begin
                        if (redirect) begin
                            pc_q <= target;
                        end else if (!stall) begin
                            pc_q <= pc_q + PC_W'(3'd4);
                        end
                    end else if (redirect) begin
                        pend_pc <= target;
                        state   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (fetch_ready) begin
                        pc_q  <= pend_pc;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed self-checking bench for npc_sequencer (32-bit instance plus a 16-bit wrap instance).
module tb_npc_sequencer;
    import npc_sequencer_pkg::*;

`ifdef NPC_DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_D;
    logic        valid_D;
    logic [31:0] pc_D;
    logic [31:0] rs_val_D;
    logic [31:0] rt_val_D;
    logic        stall;
    logic        fetch_ready;
    logic [31:0] pc_F;
    logic        fetch_valid;
    logic        flush_D;
    logic [31:0] link_D;
    logic        redirect;

    logic        valid16;
    logic [15:0] pc16_D;
    logic        stall16;
    logic        fr16;
    logic [15:0] pc16_F;
    logic        fetch_valid16;
    logic        flush16;
    logic [15:0] link16;
    logic        redirect16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    npc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_D     (instr_D),
        .valid_D     (valid_D),
        .pc_D        (pc_D),
        .rs_val_D    (rs_val_D),
        .rt_val_D    (rt_val_D),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .pc_F        (pc_F),
        .fetch_valid (fetch_valid),
        .flush_D     (flush_D),
        .link_D      (link_D),
        .redirect    (redirect)
    );

    npc_sequencer #(
        .PC_W      (16),
        .RESET_VEC (16'hFFFC)
    ) dut16 (
        .clk         (clk),
        .reset       (reset),
        .instr_D     (instr_D),
        .valid_D     (valid16),
        .pc_D        (pc16_D),
        .rs_val_D    (rs_val_D),
        .rt_val_D    (rt_val_D),
        .stall       (stall16),
        .fetch_ready (fr16),
        .pc_F        (pc16_F),
        .fetch_valid (fetch_valid16),
        .flush_D     (flush16),
        .link_D      (link16),
        .redirect    (redirect16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        valid_D     = 1'b0;
        stall       = 1'b0;
        fetch_ready = 1'b0;
        valid16     = 1'b0;
        stall16     = 1'b0;
        fr16        = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        fetch_ready = 1'b1;
        valid_D     = 1'b1;
        instr_D     = {OP_JAL, 26'h0000C10};
        pc_D        = 32'h3008;
        step();
        step();
        tests++;
        if (fetch_valid !== 1'b0) begin
            fails++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid);
        end
        tests++;
        if (redirect !== 1'b0 || flush_D !== 1'b0) begin
            fails++; $display("FAIL reset_redirect_flush: got %b/%b expected 0/0", redirect, flush_D);
        end
        tests++;
        if (pc_F !== 32'h3000 || dut.state !== ST_RUN) begin
            fails++; $display("FAIL reset_pc: got %h/%0d expected 3000/RUN", pc_F, dut.state);
        end
        reset   = 1'b0;
        valid_D = 1'b0;
        #1;
        tests++;
        if (fetch_valid !== 1'b1) begin
            fails++; $display("FAIL post_reset_fetch_valid: got %b expected 1", fetch_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            tests++;
            if (pc_F !== 32'h3000 + 32'(4 * i)) begin
                fails++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc_F, 32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_beq();
        do_reset();
        instr_D     = {OP_BEQ, 5'd1, 5'd2, 16'h0003};
        pc_D        = 32'h3000;
        rs_val_D    = 32'd5;
        rt_val_D    = 32'd5;
        valid_D     = 1'b1;
        fetch_ready = 1'b1;
        #1;
        tests++;
        if (redirect !== 1'b1) begin
            fails++; $display("FAIL beq_taken_redirect: got %b expected 1", redirect);
        end
        tests++;
        if (flush_D !== ~DS) begin
            fails++; $display("FAIL beq_flush: got %b expected %b", flush_D, ~DS);
        end
        step();
        tests++;
        if (pc_F !== 32'h3010) begin
            fails++; $display("FAIL beq_target: got %h expected 3010", pc_F);
        end
        rt_val_D = 32'd6;
        #1;
        tests++;
        if (redirect !== 1'b0 || flush_D !== 1'b0) begin
            fails++; $display("FAIL beq_not_taken: got %b/%b expected 0/0", redirect, flush_D);
        end
        step();
        tests++;
        if (pc_F !== 32'h3014) begin
            fails++; $display("FAIL beq_fallthrough: got %h expected 3014", pc_F);
        end
        instr_D  = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
        pc_D     = 32'h3010;
        rt_val_D = 32'd5;
        step();
        tests++;
        if (pc_F !== 32'h300C) begin
            fails++; $display("FAIL beq_backward: got %h expected 300c", pc_F);
        end
        valid_D = 1'b0;
        #1;
        tests++;
        if (redirect !== 1'b0) begin
            fails++; $display("FAIL beq_bubble: got %b expected 0", redirect);
        end
        step();
        tests++;
        if (pc_F !== 32'h3010) begin
            fails++; $display("FAIL beq_bubble_pc: got %h expected 3010", pc_F);
        end
    endtask

    task automatic test_jumps();
        do_reset();
        instr_D     = {OP_JAL, 26'h0000C10};
        pc_D        = 32'h3008;
        valid_D     = 1'b1;
        fetch_ready = 1'b1;
        #1;
        tests++;
        if (link_D !== 32'h3010) begin
            fails++; $display("FAIL jal_link: got %h expected 3010", link_D);
        end
        step();
        tests++;
        if (pc_F !== 32'h3040) begin
            fails++; $display("FAIL jal_target: got %h expected 3040", pc_F);
        end
        instr_D  = {OP_SPECIAL, 5'd4, 15'd0, FN_JALR};
        pc_D     = 32'h3100;
        rs_val_D = 32'h3200;
        stall    = 1'b1;
        #1;
        tests++;
        if (link_D !== 32'h3108 || redirect !== 1'b0) begin
            fails++; $display("FAIL jalr_stalled: got link %h redir %b expected 3108/0", link_D, redirect);
        end
        step();
        tests++;
        if (pc_F !== 32'h3040) begin
            fails++; $display("FAIL jalr_stall_hold: got %h expected 3040", pc_F);
        end
        stall = 1'b0;
        step();
        tests++;
        if (pc_F !== 32'h3200) begin
            fails++; $display("FAIL jalr_target: got %h expected 3200", pc_F);
        end
        instr_D = {OP_J, 26'h0000C40};
        pc_D    = 32'h3208;
        step();
        tests++;
        if (pc_F !== 32'h3100) begin
            fails++; $display("FAIL j_target: got %h expected 3100", pc_F);
        end
        valid_D = 1'b0;
    endtask

    task automatic test_pend();
        do_reset();
        instr_D     = {OP_SPECIAL, 5'd3, 15'd0, FN_JR};
        pc_D        = 32'h3000;
        rs_val_D    = 32'h3100;
        valid_D     = 1'b1;
        fetch_ready = 1'b0;
        #1;
        tests++;
        if (redirect !== 1'b1 || flush_D !== 1'b0) begin
            fails++; $display("FAIL jr_pend_entry: got %b/%b expected 1/0", redirect, flush_D);
        end
        step();
        tests++;
        if (dut.state !== ST_PEND || pc_F !== 32'h3000) begin
            fails++; $display("FAIL jr_pend_state: got %0d/%h expected PEND/3000", dut.state, pc_F);
        end
        valid_D = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (pc_F !== 32'h3000 || dut.state !== ST_PEND || flush_D !== 1'b0) begin
                fails++; $display("FAIL pend_hold%0d: got %h/%0d/%b expected 3000/PEND/0", i, pc_F, dut.state, flush_D);
            end
        end
        fetch_ready = 1'b1;
        stall       = 1'b1;
        #1;
        tests++;
        if (flush_D !== ~DS || redirect !== 1'b0) begin
            fails++; $display("FAIL pend_exit_flush: got %b/%b expected %b/0", flush_D, redirect, ~DS);
        end
        step();
        tests++;
        if (pc_F !== 32'h3100 || dut.state !== ST_RUN) begin
            fails++; $display("FAIL pend_exit: got %h/%0d expected 3100/RUN", pc_F, dut.state);
        end
        stall = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        instr_D     = {OP_BNE, 5'd1, 5'd2, 16'h0010};
        pc_D        = 32'h3000;
        rs_val_D    = 32'd1;
        rt_val_D    = 32'd2;
        valid_D     = 1'b1;
        stall       = 1'b1;
        fetch_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (redirect !== 1'b0) begin
                fails++; $display("FAIL bne_stall_redirect%0d: got %b expected 0", i, redirect);
            end
            step();
            tests++;
            if (pc_F !== 32'h3000) begin
                fails++; $display("FAIL bne_stall_pc%0d: got %h expected 3000", i, pc_F);
            end
        end
        stall = 1'b0;
        #1;
        tests++;
        if (redirect !== 1'b1) begin
            fails++; $display("FAIL bne_release_redirect: got %b expected 1", redirect);
        end
        step();
        tests++;
        if (pc_F !== 32'h3044) begin
            fails++; $display("FAIL bne_target: got %h expected 3044", pc_F);
        end
        valid_D = 1'b0;
    endtask

    task automatic test_wrap16();
        do_reset();
        tests++;
        if (pc16_F !== 16'hFFFC) begin
            fails++; $display("FAIL w16_reset: got %h expected fffc", pc16_F);
        end
        fr16 = 1'b1;
        step();
        tests++;
        if (pc16_F !== 16'h0000) begin
            fails++; $display("FAIL w16_wrap: got %h expected 0000", pc16_F);
        end
        step();
        tests++;
        if (pc16_F !== 16'h0004) begin
            fails++; $display("FAIL w16_after_wrap: got %h expected 0004", pc16_F);
        end
        instr_D  = {OP_SPECIAL, 5'd3, 15'd0, FN_JR};
        pc16_D   = 16'h0004;
        rs_val_D = 32'h1234;
        valid16  = 1'b1;
        fr16     = 1'b0;
        step();
        tests++;
        if (dut16.state !== ST_PEND) begin
            fails++; $display("FAIL w16_pend: got %0d expected PEND", dut16.state);
        end
        reset = 1'b1;
        step();
        tests++;
        if (pc16_F !== 16'hFFFC || dut16.state !== ST_RUN) begin
            fails++; $display("FAIL w16_reset_in_pend: got %h/%0d expected fffc/RUN", pc16_F, dut16.state);
        end
        reset   = 1'b0;
        valid16 = 1'b0;
        fr16    = 1'b1;
        step();
        tests++;
        if (pc16_F !== 16'h0000) begin
            fails++; $display("FAIL w16_pend_discarded: got %h expected 0000", pc16_F);
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_D     = '0;
        valid_D     = 1'b0;
        pc_D        = '0;
        rs_val_D    = '0;
        rt_val_D    = '0;
        stall       = 1'b0;
        fetch_ready = 1'b0;
        valid16     = 1'b0;
        pc16_D      = '0;
        stall16     = 1'b0;
        fr16        = 1'b0;

        test_reset();
        test_beq();
        test_jumps();
        test_pend();
        test_stall();
        test_wrap16();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
